// File: rtl/shift_sequencer.sv
// Command sequencer for an external load/shift-right register: loads a byte,
// issues N paced shift pulses, then captures the shifter output into result_o.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4,
    parameter int PACE  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [AMT_W-1:0] amount_i,
    input  logic             arith_i,
    input  logic [WIDTH-1:0] q_in_i,
    output logic [WIDTH-1:0] load_val_o,
    output logic             load_n_o,
    output logic             shift_right_o,
    output logic             asr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);
    // Hold counter runs 0..PACE-2, giving PACE-1 hold cycles between shifts.
    localparam int PW = (PACE > 2) ? $clog2(PACE - 1) : 1;
    localparam logic [PW-1:0]    WAIT_LAST = PW'((PACE > 1) ? (PACE - 2) : 0);
    localparam logic [AMT_W-1:0] AMT_MAX   = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE   = AMT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             arith_q, arith_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [PW-1:0]    wait_q, wait_d;
    logic [WIDTH-1:0] result_q, result_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            arith_q  <= 1'b0;
            rem_q    <= '0;
            wait_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            arith_q  <= arith_d;
            rem_q    <= rem_d;
            wait_q   <= wait_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        arith_d  = arith_q;
        rem_d    = rem_q;
        wait_d   = wait_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    data_d  = data_i;
                    arith_d = arith_i;
                    rem_d   = (amount_i > AMT_MAX) ? AMT_MAX : amount_i;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (rem_q != '0) ? S_SHIFT : S_CAPTURE;
            end
            S_SHIFT: begin
                rem_d = rem_q - AMT_ONE;
                if (rem_q == AMT_ONE) begin
                    state_d = S_CAPTURE;
                end else if (PACE > 1) begin
                    wait_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_SHIFT;
                end else begin
                    wait_d = wait_q + PW'(1);
                end
            end
            S_CAPTURE: begin
                result_d = q_in_i;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode: only registered state and command fields feed outputs.
    always_comb begin
        load_val_o    = '0;
        load_n_o      = 1'b1;
        shift_right_o = 1'b0;
        asr_o         = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        result_o      = result_q;
        case (state_q)
            S_LOAD, S_SHIFT, S_WAIT, S_CAPTURE: begin
                busy_o     = 1'b1;
                asr_o      = arith_q;
                load_val_o = data_q;
                load_n_o   = (state_q != S_LOAD);
                shift_right_o = (state_q == S_SHIFT);
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench: two sequencers (PACE=1 and PACE=3) each driving a behavioural 8-bit
// shifter, checked every cycle against a command-timeline model plus literals.
module tb_shift_sequencer;
    typedef struct packed {
        logic       busy;
        logic       load_n;
        logic       sr;
        logic       asr;
        logic       done;
        logic [7:0] lv;
        logic [7:0] res;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic [3:0] amount;
    logic       arith;

    logic [7:0] lv_w   [2];
    logic       ldn_w  [2];
    logic       sr_w   [2];
    logic       asr_w  [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic [7:0] res_w  [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic b, input logic ldn, input logic s, input logic a,
                                input logic d, input logic [7:0] lv, input logic [7:0] r);
        exp_t e;
        e.busy = b; e.load_n = ldn; e.sr = s; e.asr = a; e.done = d; e.lv = lv; e.res = r;
        return e;
    endfunction

    // Right shift by n as plain integer arithmetic (floor division by 2**n).
    function automatic logic [7:0] shifted(input logic [7:0] d, input int n, input logic ar);
        int v;
        v = (ar && d >= 128) ? int'(d) - 256 : int'(d);
        v = v >>> n;
        return v[7:0];
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int P = (gi == 0) ? 1 : 3;
        logic [7:0] q_sh;
        exp_t cur;
        exp_t q_exp[$];

        shift_sequencer #(.WIDTH(8), .AMT_W(4), .PACE(P)) dut (
            .clk_i(clk), .rst_i(rst), .start_i(start), .data_i(data),
            .amount_i(amount), .arith_i(arith), .q_in_i(q_sh),
            .load_val_o(lv_w[gi]), .load_n_o(ldn_w[gi]), .shift_right_o(sr_w[gi]),
            .asr_o(asr_w[gi]), .busy_o(busy_w[gi]), .done_o(done_w[gi]),
            .result_o(res_w[gi])
        );

        // Downstream shifter: load has priority over shift.
        always_ff @(posedge clk) begin
            if (!ldn_w[gi]) q_sh <= lv_w[gi];
            else if (sr_w[gi]) q_sh <= asr_w[gi] ? {q_sh[7], q_sh[7:1]} : {1'b0, q_sh[7:1]};
        end

        // Model: on acceptance, lay out the whole command as a list of cycle records.
        initial begin
            cur = mk(0, 1, 0, 0, 0, 8'h00, 8'h00);
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    q_exp.delete();
                    cur = mk(0, 1, 0, 0, 0, 8'h00, 8'h00);
                end else if (q_exp.size() > 0) begin
                    cur = q_exp.pop_front();
                end else if (start && !cur.done) begin
                    int n;
                    n = (amount > 8) ? 8 : int'(amount);
                    q_exp.push_back(mk(1, 0, 0, arith, 0, data, cur.res));
                    for (int s = 0; s < n; s++) begin
                        q_exp.push_back(mk(1, 1, 1, arith, 0, data, cur.res));
                        if (s < n - 1)
                            for (int w = 0; w < P - 1; w++)
                                q_exp.push_back(mk(1, 1, 0, arith, 0, data, cur.res));
                    end
                    q_exp.push_back(mk(1, 1, 0, arith, 0, data, cur.res));
                    q_exp.push_back(mk(0, 1, 0, 0, 1, 8'h00, shifted(data, n, arith)));
                    cur = q_exp.pop_front();
                end else begin
                    cur = mk(0, 1, 0, 0, 0, 8'h00, cur.res);
                end
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                chk((gi == 0) ? "cycle_p1" : "cycle_p3",
                    {11'd0, busy_w[gi], ldn_w[gi], sr_w[gi], asr_w[gi], done_w[gi], lv_w[gi], res_w[gi]},
                    {11'd0, cur});
            end
        end
    end

    task automatic run_cmd(input string nm, input logic [7:0] d, input logic [3:0] a,
                           input logic ar, input int hold, input logic [7:0] exp_r,
                           input int exp_sr, input int exp_done0, input int exp_done1);
        int done_at[2];
        int sr_cnt[2];
        int busy_cnt[2];
        done_at = '{-1, -1};
        sr_cnt = '{0, 0};
        busy_cnt = '{0, 0};
        @(posedge clk); #2;
        start = 1; data = d; amount = a; arith = ar;
        @(posedge clk);
        for (int k = 0; k < 60; k++) begin
            #2;
            if (k >= hold) start = 0;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (sr_w[i]) sr_cnt[i]++;
                if (busy_w[i]) busy_cnt[i]++;
                if (done_w[i] && done_at[i] < 0) done_at[i] = k;
            end
            if (done_at[0] >= 0 && done_at[1] >= 0) break;
            @(posedge clk);
        end
        start = 0;
        chk({nm, "_done_p1"}, done_at[0], exp_done0);
        chk({nm, "_done_p3"}, done_at[1], exp_done1);
        chk({nm, "_busy_p1"}, busy_cnt[0], exp_done0);
        for (int i = 0; i < 2; i++) begin
            chk({nm, "_shifts"}, sr_cnt[i], exp_sr);
            chk({nm, "_result"}, res_w[i], exp_r);
        end
        $display("cmd %s data=%h amt=%0d arith=%0b result=%h/%h done_at=%0d/%0d",
                 nm, d, a, ar, res_w[0], res_w[1], done_at[0], done_at[1]);
    endtask

    initial begin
        int dones;
        rst = 1; start = 1; data = 8'hA5; amount = 4'd3; arith = 1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", busy_w[i], 0);
            chk("rst_load_n", ldn_w[i], 1);
            chk("rst_shift", sr_w[i], 0);
            chk("rst_result", res_w[i], 8'h00);
        end
        @(posedge clk); #2;
        rst = 0; start = 0;

        run_cmd("lsr3",   8'hB4, 4'd3,  0, 0, 8'h16, 3, 5, 9);
        run_cmd("asr3",   8'hB4, 4'd3,  1, 0, 8'hF6, 3, 5, 9);
        run_cmd("lsr12",  8'hB4, 4'd12, 0, 0, 8'h00, 8, 10, 24);
        run_cmd("asr12",  8'hB4, 4'd12, 1, 0, 8'hFF, 8, 10, 24);
        run_cmd("pace2",  8'h81, 4'd2,  0, 0, 8'h20, 2, 4, 6);
        run_cmd("amt0",   8'h5A, 4'd0,  0, 0, 8'h5A, 0, 2, 2);
        run_cmd("busyst", 8'hB4, 4'd3,  0, 3, 8'h16, 3, 5, 9);

        // Reset in the middle of a shift run.
        @(posedge clk); #2;
        start = 1; data = 8'hB4; amount = 4'd8; arith = 1;
        @(posedge clk); #2;
        start = 0;
        @(posedge clk); @(posedge clk); #2;
        chk("pre_rst_shift", sr_w[0], 1);
        rst = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_busy", busy_w[i], 0);
            chk("async_shift", sr_w[i], 0);
            chk("async_asr", asr_w[i], 0);
            chk("async_result", res_w[i], 8'h00);
        end
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #2;
            if (c == 2) rst = 0;
            if (done_w[0] || done_w[1]) dones++;
        end
        chk("no_done_after_rst", dones, 0);
        run_cmd("postrst", 8'hB4, 4'd3, 1, 0, 8'hF6, 3, 5, 9);

        // Random traffic, including occasional reset pulses.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #2;
            start  = ($urandom_range(0, 3) == 0);
            data   = 8'($urandom);
            amount = 4'($urandom_range(0, 15));
            arith  = 1'($urandom_range(0, 1));
            rst    = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk); #2;
        rst = 0; start = 0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
